alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 196 +++++++++++++++++++
 tb/tb_alu_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a condition-code register.
// Single-cycle arithmetic/logic ops, multi-cycle bit-serial shifts.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [2:0]       alu_mode,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       carry_sel,
  input  logic             flag_en,
  input  logic             ccr_load,
  input  logic [3:0]       ccr_in,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic [3:0]       ccr
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       ccr_q, ccr_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             dir_q, dir_d;
  logic [1:0]       cs_q, cs_d;
  logic             fe_q, fe_d;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;
  logic             is_shift;

  assign add_w    = {1'b0, op1} + {1'b0, op2};
  assign sub_w    = {1'b0, op1} - {1'b0, op2};
  assign is_shift = alu_mode[2] & alu_mode[1];

  // Single-cycle ALU result; shifts with zero count pass op1 through
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (alu_mode)
      3'b000: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                  (add_w[WIDTH-1] != op1[WIDTH-1]);
      end
      3'b001: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                  (sub_w[WIDTH-1] != op1[WIDTH-1]);
      end
      3'b010: alu_res = op1 & op2;
      3'b011: alu_res = op1 | op2;
      3'b100: alu_res = ~op1;
      3'b101: alu_res = op1;
      3'b110: alu_res = op1;
      3'b111: alu_res = op1;
    endcase
  end

  // One-bit shift step of the in-flight operand (dir 1 = right)
  always_comb begin
    if (dir_q) begin
      sh_next = {1'b0, sh_q[WIDTH-1:1]};
      sh_out  = sh_q[0];
    end else begin
      sh_next = {sh_q[WIDTH-2:0], 1'b0};
      sh_out  = sh_q[WIDTH-1];
    end
  end

  logic             done;
  logic [WIDTH-1:0] done_res;
  logic             done_c;
  logic             done_v;
  logic             done_fe;
  logic [1:0]       done_cs;
  logic             c_new;

  // Next-state: acceptance, shift sequencing, completion and CCR update
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    ccr_d       = ccr_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    dir_d       = dir_q;
    cs_d        = cs_q;
    fe_d        = fe_q;
    done        = 1'b0;
    done_res    = '0;
    done_c      = 1'b0;
    done_v      = 1'b0;
    done_fe     = 1'b0;
    done_cs     = 2'b00;
    c_new       = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_shift && (shamt != '0)) begin
            state_d = SHIFT;
            sh_d    = op1;
            cnt_d   = shamt;
            dir_d   = alu_mode[0];
            cs_d    = carry_sel;
            fe_d    = flag_en;
          end else begin
            done     = 1'b1;
            done_res = alu_res;
            done_c   = alu_c;
            done_v   = alu_v;
            done_fe  = flag_en;
            done_cs  = carry_sel;
          end
        end
      end
      SHIFT: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d  = IDLE;
          done     = 1'b1;
          done_res = sh_next;
          done_c   = sh_out;
          done_fe  = fe_q;
          done_cs  = cs_q;
        end
      end
      default: state_d = IDLE;
    endcase
    unique case (done_cs)
      2'b00: c_new = 1'b0;
      2'b01: c_new = 1'b1;
      2'b10: c_new = done_c;
      2'b11: c_new = ccr_q[2];
    endcase
    if (done) begin
      result_d    = done_res;
      out_valid_d = 1'b1;
      if (done_fe) begin
        ccr_d = {done_v, c_new, done_res[WIDTH-1],
                 (done_res == '0)};
      end
    end
    if (ccr_load) begin
      ccr_d = ccr_in;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      ccr_q       <= 4'b0000;
      cnt_q       <= '0;
      sh_q        <= '0;
      dir_q       <= 1'b0;
      cs_q        <= 2'b00;
      fe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      ccr_q       <= ccr_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      dir_q       <= dir_d;
      cs_q        <= cs_d;
      fe_q        <= fe_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign ccr       = ccr_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq.
// Expected values are hand-computed constants.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op1;
  logic [15:0] op2;
  logic [2:0]  alu_mode;
  logic [3:0]  shamt;
  logic [1:0]  carry_sel;
  logic        flag_en;
  logic        ccr_load;
  logic [3:0]  ccr_in;
  logic [15:0] result;
  logic        out_valid;
  logic [3:0]  ccr;

  int vectors = 0;
  int miscompares = 0;

  alu_seq #(.WIDTH(16), .SHW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .alu_mode  (alu_mode),
    .shamt     (shamt),
    .carry_sel (carry_sel),
    .flag_en   (flag_en),
    .ccr_load  (ccr_load),
    .ccr_in    (ccr_in),
    .result    (result),
    .out_valid (out_valid),
    .ccr       (ccr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic req(input logic [2:0] m,
                     input logic [15:0] a,
                     input logic [15:0] b,
                     input logic [3:0] s,
                     input logic [1:0] cs,
                     input logic fe);
    in_valid  = 1'b1;
    alu_mode  = m;
    op1       = a;
    op2       = b;
    shamt     = s;
    carry_sel = cs;
    flag_en   = fe;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op1 = '0; op2 = '0;
    alu_mode = '0; shamt = '0; carry_sel = '0;
    flag_en = 1'b0; ccr_load = 1'b0; ccr_in = '0;
    #12;
    chk("rst_result", result, 16'h0000);
    chk("rst_ovalid", out_valid, 1'b0);
    chk("rst_ccr", ccr, 4'b0000);
    chk("rst_ready", in_ready, 1'b1);
    step();
    rst_n = 1'b1;

    // ADD wrap to zero, accepted on first edge after reset
    req(3'b000, 16'hFFFF, 16'h0001, 4'd0, 2'b10, 1'b1);
    step();
    chk("add_wrap_res", result, 16'h0000);
    chk("add_wrap_ov", out_valid, 1'b1);
    chk("add_wrap_ccr", ccr, 4'b0101);

    // Back-to-back: overflow ADD then borrowing SUB
    req(3'b000, 16'h7FFF, 16'h0001, 4'd0, 2'b10, 1'b1);
    step();
    chk("add_ovf_res", result, 16'h8000);
    chk("add_ovf_ccr", ccr, 4'b1010);
    chk("add_ovf_ov", out_valid, 1'b1);
    req(3'b001, 16'h0003, 16'h0005, 4'd0, 2'b10, 1'b1);
    step();
    chk("sub_res", result, 16'hFFFE);
    chk("sub_ccr", ccr, 4'b0110);
    chk("sub_ov", out_valid, 1'b1);
    in_valid = 1'b0;
    step();
    chk("pulse_end", out_valid, 1'b0);
    chk("hold_res", result, 16'hFFFE);

    // SHL 0x8001 by 3 with inputs scrambled mid-flight
    req(3'b110, 16'h8001, 16'h0000, 4'd3, 2'b10, 1'b1);
    step();
    chk("shl_busy0", in_ready, 1'b0);
    chk("shl_nov0", out_valid, 1'b0);
    req(3'b000, 16'hFFFF, 16'hFFFF, 4'd9, 2'b01, 1'b0);
    step();
    chk("shl_busy1", in_ready, 1'b0);
    step();
    chk("shl_busy2", in_ready, 1'b0);
    chk("shl_nov2", out_valid, 1'b0);
    step();
    chk("shl_done_ov", out_valid, 1'b1);
    chk("shl_res", result, 16'h0008);
    chk("shl_ccr", ccr, 4'b0000);
    chk("shl_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    step();
    chk("shl_ov_end", out_valid, 1'b0);

    // SHR 0x0001 by 1
    req(3'b111, 16'h0001, 16'h0000, 4'd1, 2'b10, 1'b1);
    step();
    chk("shr1_busy", in_ready, 1'b0);
    in_valid = 1'b0;
    step();
    chk("shr1_ov", out_valid, 1'b1);
    chk("shr1_res", result, 16'h0000);
    chk("shr1_ccr", ccr, 4'b0101);

    // Shift with zero count completes in one cycle
    req(3'b110, 16'h1234, 16'h0000, 4'd0, 2'b10, 1'b1);
    step();
    chk("shl0_res", result, 16'h1234);
    chk("shl0_ccr", ccr, 4'b0000);
    chk("shl0_ready", in_ready, 1'b1);

    // carry_sel set / hold / clear on logic ops
    req(3'b010, 16'hFF00, 16'h0F0F, 4'd0, 2'b01, 1'b1);
    step();
    chk("and_res", result, 16'h0F00);
    chk("and_ccr", ccr, 4'b0100);
    req(3'b011, 16'h8000, 16'h0001, 4'd0, 2'b11, 1'b1);
    step();
    chk("or_res", result, 16'h8001);
    chk("or_ccr", ccr, 4'b0110);
    req(3'b100, 16'hFFFF, 16'h0000, 4'd0, 2'b00, 1'b1);
    step();
    chk("not_res", result, 16'h0000);
    chk("not_ccr", ccr, 4'b0001);

    // Forced load wins over completion update
    req(3'b000, 16'h0001, 16'h0001, 4'd0, 2'b10, 1'b1);
    ccr_load = 1'b1; ccr_in = 4'b1001;
    step();
    chk("ld_res", result, 16'h0002);
    chk("ld_ccr", ccr, 4'b1001);
    ccr_load = 1'b0;
    req(3'b000, 16'h0000, 16'h0000, 4'd0, 2'b10, 1'b0);
    step();
    chk("nofe_res", result, 16'h0000);
    chk("nofe_ccr", ccr, 4'b1001);
    chk("nofe_ov", out_valid, 1'b1);

    // Idle load
    in_valid = 1'b0;
    ccr_load = 1'b1; ccr_in = 4'b1111;
    step();
    chk("iload_ccr", ccr, 4'b1111);
    chk("iload_ov", out_valid, 1'b0);
    ccr_load = 1'b0;

    // PASS, then reset in the middle of an 8-bit SHR
    req(3'b101, 16'hABCD, 16'h0000, 4'd0, 2'b10, 1'b1);
    step();
    chk("pass_res", result, 16'hABCD);
    chk("pass_ccr", ccr, 4'b0010);
    req(3'b111, 16'hF000, 16'h0000, 4'd8, 2'b10, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("mid_busy", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_res", result, 16'h0000);
    chk("mrst_ov", out_valid, 1'b0);
    chk("mrst_ccr", ccr, 4'b0000);
    chk("mrst_ready", in_ready, 1'b1);
    step();
    chk("mrst_ov1", out_valid, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_ov", out_valid, 1'b0);
      chk("post_ready", in_ready, 1'b1);
    end
    chk("post_res", result, 16'h0000);
    chk("post_ccr", ccr, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
